// File: rtl/reg_file_seq.sv
// Programmable sequencer for a PE register-file select word: replays a table of
// {inst, repeat} entries on start, optionally looping over the table several times.
module reg_file_seq #(
    parameter int           DEPTH     = 8,
    parameter int           ADDR_W    = 3,
    parameter int           CNT_W     = 8,
    parameter logic [3:0]   IDLE_INST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_inst,
    input  logic [CNT_W-1:0]  cfg_rpt,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic [CNT_W-1:0]  loop_cnt,
    input  logic              abort,
    output logic [3:0]        reg_file_inst,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    // Handshake: start and cfg_we are level strobes sampled every edge; start is
    // accepted only in IDLE, cfg_we only in IDLE without start (else cfg_err pulses).
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [3:0]        tbl_inst [DEPTH];
    logic [CNT_W-1:0]  tbl_rpt  [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  rcnt;
    logic [CNT_W-1:0]  pass;
    logic [ADDR_W-1:0] last_q;
    logic [CNT_W-1:0]  loop_q;

    logic tbl_wr;
    assign tbl_wr = (state == IDLE) && cfg_we && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_inst[i] <= '0;
                tbl_rpt[i]  <= '0;
            end
        end else if (tbl_wr) begin
            tbl_inst[cfg_addr] <= cfg_inst;
            tbl_rpt[cfg_addr]  <= cfg_rpt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            rcnt          <= '0;
            pass          <= '0;
            last_q        <= '0;
            loop_q        <= '0;
            reg_file_inst <= IDLE_INST;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= cfg_we && ((state == RUN) || start);
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        idx           <= '0;
                        rcnt          <= '0;
                        pass          <= '0;
                        last_q        <= last_idx;
                        loop_q        <= loop_cnt;
                        reg_file_inst <= tbl_inst[0];
                        busy          <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state         <= IDLE;
                        reg_file_inst <= IDLE_INST;
                        busy          <= 1'b0;
                    end else if (rcnt != tbl_rpt[idx]) begin
                        rcnt <= rcnt + CNT_W'(1);
                    end else if (idx != last_q) begin
                        // last_q <= DEPTH-1, so idx never steps past the table end
                        idx           <= idx + ADDR_W'(1);
                        rcnt          <= '0;
                        reg_file_inst <= tbl_inst[idx + ADDR_W'(1)];
                    end else if (pass != loop_q) begin
                        pass          <= pass + CNT_W'(1);
                        idx           <= '0;
                        rcnt          <= '0;
                        reg_file_inst <= tbl_inst[0];
                    end else begin
                        state         <= IDLE;
                        reg_file_inst <= IDLE_INST;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq: hand-computed select words, busy/done timing,
// abort, async reset, config rejection and counter boundaries.
module tb_reg_file_seq;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_inst;
    logic [7:0] cfg_rpt;
    logic       start;
    logic [2:0] last_idx;
    logic [7:0] loop_cnt;
    logic       abort;
    logic [3:0] reg_file_inst;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int vectors = 0;
    int errs    = 0;

    reg_file_seq dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_inst(cfg_inst), .cfg_rpt(cfg_rpt), .start(start), .last_idx(last_idx),
        .loop_cnt(loop_cnt), .abort(abort), .reg_file_inst(reg_file_inst),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] i, input logic [7:0] r);
        cfg_we = 1'b1; cfg_addr = a; cfg_inst = i; cfg_rpt = r;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [2:0] l, input logic [7:0] lc);
        start = 1'b1; last_idx = l; loop_cnt = lc;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [3:0] w);
        chk({tag, "_inst"}, reg_file_inst, w);
        chk({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_idle_inst"}, reg_file_inst, 4'b0000);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [3:0] basic_exp [6];
        int         cnt;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_inst = '0; cfg_rpt = '0;
        start = 1'b0; last_idx = '0; loop_cnt = '0; abort = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // reset / idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_inst", reg_file_inst, 4'b0000);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_cfg_err", cfg_err, 1'b0);
        end

        // basic sequence
        cfg_write(3'd0, 4'b1111, 8'd0);
        cfg_write(3'd1, 4'b0000, 8'd2);
        cfg_write(3'd2, 4'b1000, 8'd1);
        basic_exp = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
        go(3'd2, 8'd0);
        for (int i = 0; i < 6; i++) begin
            chk_word("basic", basic_exp[i]);
            chk("basic_no_done", done, 1'b0);
            tick();
        end
        chk_done("basic");
        tick();
        chk("basic_done_pulse", done, 1'b0);

        // looping, then back-to-back restart in the done cycle
        cfg_write(3'd0, 4'b0001, 8'd0);
        cfg_write(3'd1, 4'b0010, 8'd0);
        go(3'd1, 8'd2);
        for (int p = 0; p < 3; p++) begin
            chk_word("loop_a", 4'b0001); tick();
            chk_word("loop_b", 4'b0010); tick();
        end
        chk_done("loop");
        start = 1'b1; loop_cnt = 8'd0;
        tick();
        start = 1'b0;
        chk_word("b2b_a", 4'b0001); tick();
        chk_word("b2b_b", 4'b0010); tick();
        chk_done("b2b");
        tick();

        // abort in cycle 4
        cfg_write(3'd0, 4'b0100, 8'd9);
        go(3'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk_word("abort_run", 4'b0100);
            if (i == 3) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("abort_inst", reg_file_inst, 4'b0000);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        tick();
        chk("abort_done_later", done, 1'b0);

        // abort in IDLE is harmless; async reset mid-run
        abort = 1'b1; tick(); abort = 1'b0;
        go(3'd0, 8'd0);
        chk_word("rstrun", 4'b0100);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_inst", reg_file_inst, 4'b0000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        go(3'd2, 8'd0);
        for (int i = 0; i < 3; i++) begin
            chk_word("cleared", 4'b0000);
            tick();
        end
        chk("cleared_done", done, 1'b1);
        chk("cleared_busy", busy, 1'b0);
        tick();

        // cfg_we during RUN is rejected
        cfg_write(3'd0, 4'b0011, 8'd1);
        cfg_write(3'd1, 4'b0101, 8'd0);
        go(3'd1, 8'd0);
        chk_word("rej_run0", 4'b0011);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_inst = 4'b1111; cfg_rpt = 8'd5;
        tick();
        cfg_we = 1'b0;
        chk("rej_run_err", cfg_err, 1'b1);
        chk_word("rej_run1", 4'b0011);
        tick();
        chk("rej_run_err_pulse", cfg_err, 1'b0);
        chk_word("rej_run2", 4'b0101);
        tick();
        chk_done("rej_run");
        tick();
        go(3'd1, 8'd0);
        chk_word("rej_later0", 4'b0011); tick();
        chk_word("rej_later1", 4'b0011); tick();
        chk_word("rej_later2", 4'b0101); tick();
        chk_done("rej_later");
        tick();

        // cfg_we together with start is rejected
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_inst = 4'b1110; cfg_rpt = 8'd0;
        go(3'd0, 8'd0);
        cfg_we = 1'b0;
        chk("rej_start_err", cfg_err, 1'b1);
        chk_word("rej_start0", 4'b0011); tick();
        chk("rej_start_err_pulse", cfg_err, 1'b0);
        chk_word("rej_start1", 4'b0011); tick();
        chk_done("rej_start");
        tick();

        // full table with rpt=255 on the last entry; inputs changed mid-run
        for (int i = 0; i < 7; i++) cfg_write(3'(i), 4'(i), 8'd0);
        cfg_write(3'd7, 4'b1001, 8'd255);
        go(3'd7, 8'd0);
        last_idx = 3'd0; loop_cnt = 8'd5;
        cnt = 0;
        while (busy && cnt < 400) begin
            if (cnt < 7) chk("full_word", reg_file_inst, 32'(cnt));
            else         chk("full_word7", reg_file_inst, 4'b1001);
            cnt++;
            tick();
        end
        chk("full_len", cnt, 263);
        chk("full_done", done, 1'b1);
        tick();
        chk("full_done_pulse", done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
